// File: rtl/fp_wb_pkg.sv
// Shared FP write-back types: register count, register index and data word.
package fp_wb_pkg;

  localparam int unsigned FP_NREG = 32;

  typedef logic [4:0]  fp_idx_t;
  typedef logic [31:0] fp_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr for the first active request,
// returns a one-hot grant and the pointer value following the winner.
module rr_arbiter #(
  parameter  int unsigned N  = 3,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr
);

  // First requester at or after ptr (wrapping) wins; pointer moves past it.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        next_ptr   = PW'((32'(idx) + 1) % N);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_wb_scheduler.sv
// FP register-file write-back scheduler: round-robin sharing of the single
// RF write port, 32-entry busy scoreboard and RAW/WAW issue stall.
// Optional FP_WB_PERF_CNT_EN adds a saturating conflict_cnt output counting
// cycles in which two or more requesters are valid.
module fp_wb_scheduler
  import fp_wb_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*5-1:0] req_rd,
  input  logic [N_REQ*32-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rd,
  input  logic [4:0]         issue_rs1,
  input  logic [4:0]         issue_rs2,
  output logic               issue_stall,
  output logic [31:0]        busy,
  output logic               w_en,
  output logic [4:0]         w_index,
  output logic [31:0]        w_data
`ifdef FP_WB_PERF_CNT_EN
  ,
  output logic [31:0]        conflict_cnt
`endif
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      next_ptr;
  logic [N_REQ-1:0]   grant;
  logic               transfer;
  fp_idx_t            sel_rd;
  fp_data_t           sel_data;
  logic               set_en;
  logic [FP_NREG-1:0] busy_nxt;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  // Grant is the ready; held low while reset is asserted.
  always_comb begin
    req_ready = rst ? '0 : grant;
    transfer  = |req_ready;
  end

  // Select the winning requester's destination and data.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[i*5 +: 5];
        sel_data = req_data[i*32 +: 32];
      end
    end
  end

  // Hazard check against pending destinations; busy[0] is always clear.
  always_comb begin
    issue_stall = issue_valid & (busy[issue_rd] | busy[issue_rs1] | busy[issue_rs2]);
    set_en      = issue_valid & ~issue_stall & (issue_rd != '0);
  end

  // Clear on completed write, then set on issue so a same-index set wins.
  always_comb begin
    busy_nxt = busy;
    if (w_en)   busy_nxt[w_index]  = 1'b0;
    if (set_en) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Arbitration pointer and registered RF write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      w_en    <= 1'b0;
      w_index <= '0;
      w_data  <= '0;
    end else begin
      w_en <= transfer;
      if (transfer) begin
        ptr     <= next_ptr;
        w_index <= sel_rd;
        w_data  <= sel_data;
      end
    end
  end

`ifdef FP_WB_PERF_CNT_EN
  // Saturating count of cycles with contention on the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) conflict_cnt <= '0;
    else if (($countones(req_valid) >= 2) && (conflict_cnt != '1))
      conflict_cnt <= conflict_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fp_wb_scheduler.sv
// Bench for fp_wb_scheduler: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_fp_wb_scheduler;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*5-1:0] req_rd;
  logic [N*32-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          issue_valid;
  logic [4:0]    issue_rd, issue_rs1, issue_rs2;
  logic          issue_stall;
  logic [31:0]   busy;
  logic          w_en;
  logic [4:0]    w_index;
  logic [31:0]   w_data;
`ifdef FP_WB_PERF_CNT_EN
  logic [31:0]   conflict_cnt;
`endif

  fp_wb_scheduler #(.N_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_stall (issue_stall),
    .busy        (busy),
    .w_en        (w_en),
    .w_index     (w_index),
    .w_data      (w_data)
`ifdef FP_WB_PERF_CNT_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_busy;
  int          m_ptr;
  logic        m_wen;
  logic [4:0]  m_widx;
  logic [31:0] m_wdata;
  logic [31:0] m_cnt;
  int          gcount[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = '0; m_ptr = 0; m_wen = 1'b0; m_widx = '0; m_wdata = '0; m_cnt = '0;
    for (int i = 0; i < N; i++) gcount[i] = 0;
  endtask

  task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
    req_valid[i]        = 1'b1;
    req_rd[i*5 +: 5]    = rd;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    issue_valid = v; issue_rd = rd; issue_rs1 = r1; issue_rs2 = r2;
  endtask

  // Called just after a negedge with inputs applied; checks all outputs,
  // advances the model across one posedge, and returns at the next negedge.
  task automatic cycle(output int g);
    logic        stall;
    logic [31:0] nb;
    int          nv;
    #1;
    g = exp_grant();
    stall = issue_valid && (m_busy[issue_rd] || m_busy[issue_rs1] || m_busy[issue_rs2]);
    check("ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    check("stall", 32'(issue_stall), 32'(stall));
    check("w_en", 32'(w_en), 32'(m_wen));
    if (m_wen) begin
      check("w_index", 32'(w_index), 32'(m_widx));
      check("w_data", w_data, m_wdata);
    end
    check("busy", busy, m_busy);
`ifdef FP_WB_PERF_CNT_EN
    check("conflict_cnt", conflict_cnt, m_cnt);
`endif
    nb = m_busy;
    if (m_wen) nb[m_widx] = 1'b0;
    if (issue_valid && !stall && issue_rd != 0) nb[issue_rd] = 1'b1;
    nv = $countones(req_valid);
    @(posedge clk);
    m_busy = nb;
    m_wen  = (g >= 0);
    if (g >= 0) begin
      m_widx  = req_rd[g*5 +: 5];
      m_wdata = req_data[g*32 +: 32];
      m_ptr   = (g + 1) % N;
      gcount[g]++;
    end
    if (nv >= 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_rd = '0; req_data = '0;
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      req_valid = N'($urandom);
      req_rd    = (N*5)'($urandom);
      req_data  = {$urandom, $urandom, $urandom};
      set_issue(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      #1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_busy", busy, 32'd0);
      check("rst_w_en", 32'(w_en), 32'd0);
      check("rst_w_index", 32'(w_index), 32'd0);
      check("rst_w_data", w_data, 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);

    // 1. reset
    do_reset();

    // 2. single write
    set_issue(1'b1, 5'd5, 5'd0, 5'd0);
    cycle(g);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    set_req(1, 5'd5, 32'h3F80_0000);
    #1 check("t2_ready", 32'(req_ready), 32'd2);
    cycle(g);
    req_valid = '0;
    #1;
    check("t2_w_en", 32'(w_en), 32'd1);
    check("t2_w_index", 32'(w_index), 32'd5);
    check("t2_w_data", w_data, 32'h3F80_0000);
    cycle(g);
    check("t2_busy5_clear", 32'(busy[5]), 32'd0);
    cycle(g);

    // 3. contention, starting from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 5'($urandom), $urandom);
    for (int c = 0; c < 9; c++) begin
      #1 check("t3_grant", 32'(req_ready), 32'd1 << (c % 3));
      cycle(g);
      if (g >= 0) set_req(g, 5'($urandom), $urandom);
    end
    for (int i = 0; i < N; i++) check("t3_fair", 32'(gcount[i]), 32'd3);
    req_valid = '0;
    cycle(g);

    // 4. hazards
    set_issue(1'b1, 5'd7, 5'd0, 5'd0);
    cycle(g);
    set_issue(1'b1, 5'd1, 5'd7, 5'd0);
    #1 check("t4_raw", 32'(issue_stall), 32'd1);
    cycle(g);
    set_issue(1'b1, 5'd7, 5'd2, 5'd3);
    #1 check("t4_waw", 32'(issue_stall), 32'd1);
    cycle(g);
    set_issue(1'b1, 5'd8, 5'd9, 5'd10);
    #1 check("t4_free", 32'(issue_stall), 32'd0);
    cycle(g);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    #1 check("t4_busy8", 32'(busy[8]), 32'd1);
    set_req(2, 5'd7, 32'h1111_2222);
    set_req(0, 5'd8, 32'h3333_4444);
    for (int c = 0; c < 4; c++) begin
      cycle(g);
      if (g >= 0) req_valid[g] = 1'b0;
    end
    check("t4_drained", busy & 32'h0000_0180, 32'd0);

    // 5. same-edge set/clear and index 0
    set_req(0, 5'd3, 32'hDEAD_BEEF);
    cycle(g);
    req_valid = '0;
    set_issue(1'b1, 5'd3, 5'd0, 5'd0);
    cycle(g);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    #1 check("t5_set_wins", 32'(busy[3]), 32'd1);
    cycle(g);
    set_issue(1'b1, 5'd0, 5'd0, 5'd0);
    set_req(1, 5'd0, 32'h0BAD_F00D);
    #1 check("t5_rd0_ready", 32'(req_ready), 32'd2);
    cycle(g);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    req_valid = '0;
    #1;
    check("t5_busy0", 32'(busy[0]), 32'd0);
    check("t5_rd0_w_en", 32'(w_en), 32'd1);
    check("t5_rd0_w_index", 32'(w_index), 32'd0);
    cycle(g);
    set_req(2, 5'd3, 32'h0000_0003);
    cycle(g);
    req_valid = '0;
    cycle(g);
    cycle(g);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(1, 0) == 1)
          set_req(i, 5'($urandom), $urandom);
      set_issue(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      cycle(g);
      if (g >= 0) req_valid[g] = 1'b0;
    end
    clear_inputs();
    cycle(g);

`ifdef FP_WB_PERF_CNT_EN
    // 6. performance counter and mid-run reset
    do_reset();
    set_req(0, 5'd1, 32'h1); set_req(1, 5'd2, 32'h2);
    for (int c = 0; c < 10; c++) begin
      cycle(g);
      if (g >= 0) set_req(g, 5'($urandom), $urandom);
    end
    req_valid = '0;
    set_req(0, 5'd4, 32'h4);
    for (int c = 0; c < 5; c++) begin
      cycle(g);
      if (g >= 0) set_req(g, 5'($urandom), $urandom);
    end
    #1 check("t6_cnt10", conflict_cnt, 32'd10);
    req_valid = '0;
    set_issue(1'b1, 5'd9, 5'd0, 5'd0);
    cycle(g);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_cnt", conflict_cnt, 32'd0);
    check("t6_rst_busy", busy, 32'd0);
    check("t6_rst_w_en", 32'(w_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(g);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
